// File: rtl/alu_seq.sv
// Registered valid/ready ALU: single-cycle ops deliver one cycle after accept; MUL iterates WIDTH cycles.
// Result and flags hold while out_valid && !out_ready; `ALU_SEQ_MUL_EN enables the shift-add multiplier.
module alu_seq #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] Src_1,
   input  logic [WIDTH-1:0] Src_2,
   input  logic [SHW-1:0]   Shamt,
   input  logic [3:0]       Funct,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] ALU_result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic             accept;
   logic [WIDTH-1:0] res_c;
   logic             ovf_c;
   logic             ill_c;
`ifdef ALU_SEQ_MUL_EN
   logic             is_mul;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] prod_next;
   logic [SHW-1:0]   cnt;

   assign prod_next = acc + (mplier[0] ? mcand : '0);
`endif

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      ill_c = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      is_mul = 1'b0;
`endif
      case (Funct)
         4'd0: begin
            res_c = Src_1 + Src_2;
            ovf_c = (Src_1[WIDTH-1] == Src_2[WIDTH-1]) && (res_c[WIDTH-1] != Src_1[WIDTH-1]);
         end
         4'd1: begin
            res_c = Src_1 - Src_2;
            ovf_c = (Src_1[WIDTH-1] != Src_2[WIDTH-1]) && (res_c[WIDTH-1] != Src_1[WIDTH-1]);
         end
         4'd2:  res_c = Src_1 << Shamt;
         4'd3:  res_c = Src_1 | Src_2;
         4'd4:  res_c = Src_1 & Src_2;
         4'd5:  res_c = Src_1 ^ Src_2;
         4'd6:  res_c = Src_1 >> Shamt;
         4'd7:  res_c = $signed(Src_1) >>> Shamt;
         4'd8:  res_c[0] = $signed(Src_1) < $signed(Src_2);
         4'd9:  res_c[0] = Src_1 < Src_2;
         4'd10: res_c = ~(Src_1 | Src_2);
`ifdef ALU_SEQ_MUL_EN
         4'd11: is_mul = 1'b1;
`endif
         default: ill_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ALU_result <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         illegal    <= 1'b0;
         out_valid  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         cnt        <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (is_mul) begin
            state     <= BUSY;
            out_valid <= 1'b0;
            mcand     <= Src_1;
            mplier    <= Src_2;
            acc       <= '0;
            cnt       <= '0;
         end else
`endif
         begin
            state      <= DONE;
            out_valid  <= 1'b1;
            ALU_result <= res_c;
            zero       <= (res_c == '0);
            overflow   <= ovf_c;
            illegal    <= ill_c;
         end
      end else if (state == DONE && out_ready) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      // One multiplier bit per cycle; the final iteration writes straight into the result.
      else if (state == BUSY) begin
         acc    <= prod_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (cnt == SHW'(WIDTH - 1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            ALU_result <= prod_next;
            zero       <= (prod_next == '0);
            overflow   <= 1'b0;
            illegal    <= 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): directed scenarios plus randomized ops against a behavioural model.
module tb_alu_seq;
   localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam longint SMAX = 2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  Src_1 = '0, Src_2 = '0;
   logic [4:0]    Shamt = '0;
   logic [3:0]    Funct = '0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, zero, overflow, illegal, out_valid;
   logic [W-1:0]  ALU_result;

   int checks = 0;
   int failures = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .Src_1(Src_1), .Src_2(Src_2), .Shamt(Shamt),
      .Funct(Funct), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_result(ALU_result), .zero(zero), .overflow(overflow),
      .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Reference model: straight from the opcode table, signed arithmetic in 64 bits.
   function automatic void model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] sh, output logic [W-1:0] r,
                                 output logic ov, output logic il);
      longint sa, sb, s;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0; ov = 1'b0; il = 1'b0;
      case (f)
         4'd0: begin s = sa + sb; r = a + b; ov = (s > SMAX) || (s < SMIN); end
         4'd1: begin s = sa - sb; r = a - b; ov = (s > SMAX) || (s < SMIN); end
         4'd2:  r = a << sh;
         4'd3:  r = a | b;
         4'd4:  r = a & b;
         4'd5:  r = a ^ b;
         4'd6:  r = a >> sh;
         4'd7:  begin s = sa; for (int i = 0; i < int'(sh); i++) s = (s - (s & 1)) / 2; r = s[W-1:0]; end
         4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = ~(a | b);
         4'd11: begin
            if (MUL_EN) begin p = {32'd0, a} * {32'd0, b}; r = p[W-1:0]; end
            else il = 1'b1;
         end
         default: il = 1'b1;
      endcase
   endfunction

   // Present one operation for a single accepting edge, then scramble the inputs.
   task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
      Funct = f; Src_1 = a; Src_2 = b; Shamt = sh; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      Src_1 = $urandom; Src_2 = $urandom; Shamt = 5'($urandom); Funct = 4'($urandom);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, zero, overflow, illegal} !== 4'b0000 || ALU_result !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset: out_valid=%b zero=%b ovf=%b ill=%b res=%h in_ready=%b, required 0 0 0 0 0 1",
                  out_valid, zero, overflow, illegal, ALU_result, in_ready);
      end
   endtask

   task automatic test_add_overflow();
      issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
      checks++;
      if (out_valid !== 1'b1 || ALU_result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
         failures++;
         $display("FAIL add_ovf: vld=%b res=%h ovf=%b zero=%b, required 1 80000000 1 0",
                  out_valid, ALU_result, overflow, zero);
      end
      drain();
   endtask

   task automatic test_hold();
      issue(4'd1, 32'd5, 32'd5, 5'd0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || ALU_result !== '0 || zero !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold cycle %0d: vld=%b res=%h zero=%b in_ready=%b, required 1 0 1 0",
                     i, out_valid, ALU_result, zero, in_ready);
         end
         if (i < 3) begin @(posedge clk); #1; end
      end
      out_ready = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL hold_release: in_ready=%b, required 1", in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]   f[4]  = '{4'd2, 4'd7, 4'd8, 4'd9};
      logic [W-1:0] a[4]  = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] b[4]  = '{32'd0, 32'd0, 32'd1, 32'd1};
      logic [4:0]   sh[4] = '{5'd31, 5'd4, 5'd0, 5'd0};
      logic [W-1:0] ex[4] = '{32'h8000_0000, 32'hF800_0000, 32'd1, 32'd0};
      out_ready = 1'b1;
      Funct = f[0]; Src_1 = a[0]; Src_2 = b[0]; Shamt = sh[0]; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || ALU_result !== ex[i]) begin
            failures++;
            $display("FAIL b2b op %0d: vld=%b res=%h, required 1 %h", i, out_valid, ALU_result, ex[i]);
         end
         if (i < 3) begin Funct = f[i+1]; Src_1 = a[i+1]; Src_2 = b[i+1]; Shamt = sh[i+1]; end
         else in_valid = 1'b0;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_mul();
      int lat = 0, ready_hi = 0;
      int exp_lat = MUL_EN ? W : 0;
      logic [W-1:0] exp_res = MUL_EN ? 32'h0005_000F : 32'd0;
      issue(4'd11, 32'h0001_0003, 32'h0000_0005, 5'd0);
      while (out_valid !== 1'b1 && lat < 40) begin
         if (in_ready !== 1'b0) ready_hi++;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != exp_lat || ready_hi != 0) begin
         failures++;
         $display("FAIL mul_latency: cycles=%0d ready_during_busy=%0d, required %0d 0", lat, ready_hi, exp_lat);
      end
      checks++;
      if (ALU_result !== exp_res || illegal !== !MUL_EN || zero !== !MUL_EN || overflow !== 1'b0) begin
         failures++;
         $display("FAIL mul_result: res=%h ill=%b zero=%b ovf=%b, required %h %b %b 0",
                  ALU_result, illegal, zero, overflow, exp_res, !MUL_EN, !MUL_EN);
      end
      drain();
   endtask

   task automatic test_illegal();
      issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
      checks++;
      if (out_valid !== 1'b1 || illegal !== 1'b1 || ALU_result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL illegal: vld=%b ill=%b res=%h zero=%b ovf=%b, required 1 1 0 1 0",
                  out_valid, illegal, ALU_result, zero, overflow);
      end
      drain();
   endtask

   task automatic test_reset_mid_mul();
      issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if ({out_valid, zero, overflow, illegal} !== 4'b0000 || ALU_result !== '0) begin
         failures++;
         $display("FAIL midmul_reset: vld=%b zero=%b ovf=%b ill=%b res=%h, required all 0",
                  out_valid, zero, overflow, illegal, ALU_result);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midmul_release: in_ready=%b vld=%b, required 1 0", in_ready, out_valid);
      end
      issue(4'd0, 32'd2, 32'd3, 5'd0);
      checks++;
      if (out_valid !== 1'b1 || ALU_result !== 32'd5 || zero !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_add: vld=%b res=%h zero=%b, required 1 5 0", out_valid, ALU_result, zero);
      end
      drain();
   endtask

   task automatic test_random(input int n);
      logic [3:0]   f;
      logic [W-1:0] a, b, er;
      logic [4:0]   sh;
      logic         eo, ei;
      int           lat, stall, exp_lat;
      for (int k = 0; k < n; k++) begin
         f  = 4'($urandom);
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? a : 32'($urandom);
         if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
         sh = 5'($urandom);
         model(f, a, b, sh, er, eo, ei);
         exp_lat = (f == 4'd11 && MUL_EN) ? W : 0;
         issue(f, a, b, sh);
         lat = 0;
         while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
         stall = $urandom_range(0, 2);
         for (int s = 0; s <= stall; s++) begin
            checks++;
            if (lat != exp_lat || out_valid !== 1'b1 || ALU_result !== er || overflow !== eo ||
                illegal !== ei || zero !== (er == '0)) begin
               failures++;
               $display("FAIL rand %0d f=%0d a=%h b=%h sh=%0d: lat=%0d vld=%b res=%h ovf=%b ill=%b zero=%b, required lat=%0d 1 %h %b %b %b",
                        k, f, a, b, sh, lat, out_valid, ALU_result, overflow, illegal, zero,
                        exp_lat, er, eo, ei, (er == '0));
            end
            if (s < stall) begin @(posedge clk); #1; end
         end
         drain();
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_hold();
      test_back_to_back();
      test_mul();
      test_illegal();
      test_reset_mid_mul();
      test_random(200);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
